// File: rtl/cell_distributor.sv
// cell_distributor: registered bit-serial message distributor.
// NCH independent channel FSMs capture an ADDR_W-bit destination address
// MSB first, then steer PLEN payload bits onto one of NCELL = 2**ADDR_W cell
// lines. Channels sharing a cell in the same cycle are OR-merged.
// Optional feature macro: COLLISION_DETECT_EN adds sticky per-cell collision
// flags (cleared by coll_clr); without it collision is tied to 0.
module cell_distributor #(
    parameter int NCH    = 7,
    parameter int ADDR_W = 4,
    parameter int PLEN   = 8,
    localparam int NCELL = 2 ** ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_start,
    input  logic [NCH-1:0]   ch_bit,
    input  logic             coll_clr,
    output logic [NCH-1:0]   ch_busy,
    output logic [NCH-1:0]   ch_done,
    output logic [NCELL-1:0] cell_out,
    output logic [NCELL-1:0] cell_valid,
    output logic [NCELL-1:0] collision
);

    // Counter must reach max(ADDR_W, PLEN) - 1.
    localparam int CNT_MAX = (ADDR_W > PLEN) ? ADDR_W : PLEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } ch_state_t;

    // Per-channel view exported to the steering stage.
    logic [NCH-1:0]    ch_in_data;
    logic [ADDR_W-1:0] ch_addr [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            ch_state_t         state_reg, state_next;
            logic [CNT_W-1:0]  cnt_reg, cnt_next;
            logic [ADDR_W-1:0] addr_reg, addr_next;
            logic              busy_reg;
            logic              done_reg, done_next;

            // Next-state logic: address capture, then payload bit counting.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                addr_next  = addr_reg;
                done_next  = 1'b0;
                case (state_reg)
                    S_IDLE: begin
                        if (ch_start[gi]) begin
                            addr_next = ADDR_W'(ch_bit[gi]);
                            if (ADDR_W == 1) begin
                                state_next = S_DATA;
                                cnt_next   = '0;
                            end else begin
                                state_next = S_ADDR;
                                cnt_next   = CNT_W'(1);
                            end
                        end
                    end
                    S_ADDR: begin
                        // Shift left so the first bit received ends up as MSB.
                        addr_next = (addr_reg << 1) | ADDR_W'(ch_bit[gi]);
                        if (cnt_reg == CNT_W'(ADDR_W - 1)) begin
                            state_next = S_DATA;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    S_DATA: begin
                        // Starts arriving here (including on the last bit) are dropped.
                        if (cnt_reg == CNT_W'(PLEN - 1)) begin
                            state_next = S_IDLE;
                            cnt_next   = '0;
                            done_next  = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // Channel state, counter, address and registered status flags.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= S_IDLE;
                    cnt_reg   <= '0;
                    addr_reg  <= '0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    addr_reg  <= addr_next;
                    busy_reg  <= (state_next != S_IDLE);
                    done_reg  <= done_next;
                end
            end

            assign ch_busy[gi]    = busy_reg;
            assign ch_done[gi]    = done_reg;
            assign ch_in_data[gi] = (state_reg == S_DATA);
            assign ch_addr[gi]    = addr_reg;
        end
    endgenerate

    logic [NCELL-1:0] out_next, valid_next;
    logic [NCELL-1:0] out_reg, valid_reg;
`ifdef COLLISION_DETECT_EN
    logic [NCELL-1:0] multi_next;
    logic [NCELL-1:0] coll_reg;
`endif

    // Steering: OR every DATA-state channel's bit onto its addressed cell.
    always_comb begin
        out_next   = '0;
        valid_next = '0;
`ifdef COLLISION_DETECT_EN
        multi_next = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (ch_in_data[i]) begin
`ifdef COLLISION_DETECT_EN
                // A cell already claimed this cycle means a second hitter.
                if (valid_next[ch_addr[i]]) begin
                    multi_next[ch_addr[i]] = 1'b1;
                end
`endif
                valid_next[ch_addr[i]] = 1'b1;
                out_next[ch_addr[i]]   = out_next[ch_addr[i]] | ch_bit[i];
            end
        end
    end

    // Cell output registers (one cycle behind the sampled payload bit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg   <= '0;
            valid_reg <= '0;
        end else begin
            out_reg   <= out_next;
            valid_reg <= valid_next;
        end
    end

    assign cell_out   = out_reg;
    assign cell_valid = valid_reg;

`ifdef COLLISION_DETECT_EN
    // Sticky collision flags; a new collision wins over a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_reg <= '0;
        end else begin
            coll_reg <= multi_next | (coll_reg & ~{NCELL{coll_clr}});
        end
    end

    assign collision = coll_reg;
`else
    // Feature absent: clear input has no effect.
    logic unused_coll_clr;
    assign unused_coll_clr = coll_clr;
    assign collision       = '0;
`endif

endmodule

// File: tb/tb_cell_distributor.sv
// Testbench for cell_distributor (defaults NCH=7, ADDR_W=4, PLEN=8).
// Expected outputs come from a message-level timeline model: every launched
// message writes its busy/done/cell contributions into per-edge arrays.
module tb_cell_distributor;

    localparam int NCH    = 7;
    localparam int ADDR_W = 4;
    localparam int PLEN   = 8;
    localparam int NCELL  = 16;
    localparam int MLEN   = ADDR_W + PLEN;
    localparam int MAXC   = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   ch_start = '0;
    logic [NCH-1:0]   ch_bit = '0;
    logic             coll_clr = 1'b0;
    logic [NCH-1:0]   ch_busy;
    logic [NCH-1:0]   ch_done;
    logic [NCELL-1:0] cell_out;
    logic [NCELL-1:0] cell_valid;
    logic [NCELL-1:0] collision;

    cell_distributor #(.NCH(NCH), .ADDR_W(ADDR_W), .PLEN(PLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_start   (ch_start),
        .ch_bit     (ch_bit),
        .coll_clr   (coll_clr),
        .ch_busy    (ch_busy),
        .ch_done    (ch_done),
        .cell_out   (cell_out),
        .cell_valid (cell_valid),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    // Expected state after edge e.
    bit [NCH-1:0]   eb [MAXC];
    bit [NCH-1:0]   ed [MAXC];
    bit [NCELL-1:0] eo [MAXC];
    bit [NCELL-1:0] ev [MAXC];
    int unsigned    eh [MAXC][NCELL];

    bit             bq [NCH][$];
    bit             sq [NCH][$];
    int             free_at [NCH];
    bit [NCELL-1:0] coll_exp;
    bit [NCH-1:0]   spur;
    bit             clr_req;
    int             cyc;
    int             n_vec;
    int             n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Schedule a message starting at edge cyc and record its effects.
    task automatic launch(input int ch, input int a, input logic [PLEN-1:0] p);
        int t;
        int e;
        bit b;
        t = cyc;
        for (int k = ADDR_W - 1; k >= 0; k--) begin
            bq[ch].push_back(a[k]);
            sq[ch].push_back(k == ADDR_W - 1);
        end
        for (int j = 0; j < PLEN; j++) begin
            b = p[PLEN-1-j];
            e = t + ADDR_W + j;
            bq[ch].push_back(b);
            sq[ch].push_back(1'b0);
            eo[e][a] = eo[e][a] | b;
            ev[e][a] = 1'b1;
            eh[e][a] = eh[e][a] + 1;
        end
        for (int e2 = t; e2 <= t + MLEN - 2; e2++) eb[e2][ch] = 1'b1;
        ed[t+MLEN-1][ch] = 1'b1;
        free_at[ch] = t + MLEN;
    endtask

    task automatic model_reset();
        for (int e = cyc; e < MAXC; e++) begin
            eb[e] = '0;
            ed[e] = '0;
            eo[e] = '0;
            ev[e] = '0;
            for (int c = 0; c < NCELL; c++) eh[e][c] = 0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            bq[ch].delete();
            sq[ch].delete();
            free_at[ch] = 0;
        end
        coll_exp = '0;
    endtask

    // Drive one edge worth of inputs, clock, then compare against the model.
    task automatic tick();
        for (int ch = 0; ch < NCH; ch++) begin
            if (bq[ch].size() > 0) begin
                ch_bit[ch]   = bq[ch].pop_front();
                ch_start[ch] = sq[ch].pop_front();
            end else begin
                ch_bit[ch]   = 1'($urandom);
                ch_start[ch] = 1'b0;
            end
            // Spurious starts only while the model says the channel is busy.
            if (spur[ch] && cyc < free_at[ch]) ch_start[ch] = 1'b1;
        end
        coll_clr = clr_req;
        @(posedge clk);
`ifdef COLLISION_DETECT_EN
        if (coll_clr && !rst) coll_exp = '0;
        if (!rst) begin
            for (int c = 0; c < NCELL; c++) begin
                if (eh[cyc][c] >= 2) coll_exp[c] = 1'b1;
            end
        end
`endif
        #1;
        chk("busy",  32'(ch_busy),    32'(eb[cyc]));
        chk("done",  32'(ch_done),    32'(ed[cyc]));
        chk("out",   32'(cell_out),   32'(eo[cyc]));
        chk("valid", 32'(cell_valid), 32'(ev[cyc]));
        chk("coll",  32'(collision),  32'(coll_exp));
        $display("cyc=%0d start=%b bit=%b busy=%b done=%b out=%h valid=%h coll=%h",
                 cyc, ch_start, ch_bit, ch_busy, ch_done, cell_out, cell_valid, collision);
        cyc++;
        spur    = '0;
        clr_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(ch_busy),    32'h0);
        chk({tag, "_done"},  32'(ch_done),    32'h0);
        chk({tag, "_out"},   32'(cell_out),   32'h0);
        chk({tag, "_valid"}, 32'(cell_valid), 32'h0);
        chk({tag, "_coll"},  32'(collision),  32'h0);
    endtask

    initial begin
        int t;
        cyc = 0; n_vec = 0; n_err = 0;
        spur = '0; clr_req = 1'b0; coll_exp = '0;
        for (int ch = 0; ch < NCH; ch++) free_at[ch] = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Single message: ch0 -> cell 10.
        launch(0, 10, 8'b1101_0011);
        repeat (MLEN + 2) tick();

        // OR merge: ch1 and ch5 both to cell 3, then clear collision.
        launch(1, 3, 8'hA5);
        launch(5, 3, 8'h0F);
        repeat (MLEN + 2) tick();
        clr_req = 1'b1;
        tick();
        repeat (2) tick();

        // Disjoint parallel delivery to cells 0..6.
        for (int ch = 0; ch < NCH; ch++) launch(ch, ch, PLEN'($urandom));
        repeat (MLEN + 2) tick();

        // Starts while busy: mid-payload and on the final payload cycle.
        launch(2, 9, PLEN'($urandom));
        t = cyc;
        while (cyc < t + ADDR_W + 3) tick();
        spur[2] = 1'b1;
        tick();
        while (cyc < t + MLEN - 1) tick();
        spur[2] = 1'b1;
        tick();
        repeat (3) tick();

        // Reset during payload bit 4 of a ch0 message to cell 15.
        launch(0, 15, PLEN'($urandom));
        t = cyc;
        while (cyc < t + ADDR_W + 3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        tick();
        rst = 1'b0;
        repeat (2) tick();
        launch(0, 15, PLEN'($urandom));
        repeat (MLEN + 2) tick();

        // Back-to-back on ch6, second start on the first cycle busy reads 0.
        launch(6, 7, PLEN'($urandom));
        while (cyc < free_at[6]) tick();
        launch(6, 12, PLEN'($urandom));
        repeat (MLEN + 2) tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (cyc >= free_at[ch] && $urandom_range(0, 99) < 25)
                    launch(ch, int'($urandom_range(0, NCELL - 1)), PLEN'($urandom));
            end
            spur    = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            clr_req = ($urandom_range(0, 19) == 0);
            tick();
        end
        repeat (MLEN + 2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
